// File: rtl/baud_gen_param.sv
// Oversampling baud-rate generator: a divisor chosen from a baud table or a custom value
// produces sample ticks, plus bit-centre and bit-end pulses derived from a sample index.
module baud_gen_param #(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             resync,
  input  logic [2:0]       baud_select,
  input  logic             use_custom,
  input  logic [DIV_W-1:0] div_custom,
  output logic             sample_ENABLE,
  output logic             mid_ENABLE,
  output logic             bit_ENABLE,
  output logic [DIV_W-1:0] div_active
);

  localparam int unsigned IDX_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [IDX_W-1:0] IDX_MID  = IDX_W'(OVERSAMPLE / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OVERSAMPLE - 1);
  localparam logic [DIV_W-1:0] DIV_MIN  = DIV_W'(2);

  // Rounded clk cycles per sample tick for a given baud rate.
  function automatic logic [DIV_W-1:0] calc_div(input longint unsigned baud);
    longint unsigned den;
    den = 64'(OVERSAMPLE) * baud;
    return DIV_W'((64'(CLK_HZ) + den / 64'd2) / den);
  endfunction

  localparam logic [DIV_W-1:0] DIV_TBL [0:7] = '{
    calc_div(64'd300),   calc_div(64'd1200),  calc_div(64'd4800),  calc_div(64'd9600),
    calc_div(64'd19200), calc_div(64'd38400), calc_div(64'd57600), calc_div(64'd115200)
  };

  logic [DIV_W-1:0] div_raw;
  logic [DIV_W-1:0] div_req;
  logic [DIV_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             wrap;

  always_comb begin
    div_raw = use_custom ? div_custom : DIV_TBL[baud_select];
    div_req = (div_raw < DIV_MIN) ? DIV_MIN : div_raw;
    wrap    = (cnt == div_active - DIV_W'(1));
  end

  // Divisor only reloads at a period boundary, so a rate change never splits a tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt           <= '0;
      idx           <= '0;
      sample_ENABLE <= 1'b0;
      mid_ENABLE    <= 1'b0;
      bit_ENABLE    <= 1'b0;
      div_active    <= DIV_TBL[0];
    end else begin
      sample_ENABLE <= 1'b0;
      mid_ENABLE    <= 1'b0;
      bit_ENABLE    <= 1'b0;
      if (!enable || resync) begin
        cnt        <= '0;
        idx        <= '0;
        div_active <= div_req;
      end else if (wrap) begin
        cnt           <= '0;
        idx           <= idx + IDX_W'(1);
        div_active    <= div_req;
        sample_ENABLE <= 1'b1;
        mid_ENABLE    <= (idx == IDX_MID);
        bit_ENABLE    <= (idx == IDX_LAST);
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_baud_gen_param.sv
// Scoreboard bench for baud_gen_param: stimulus queues expected pulse cycles/flags,
// a negedge monitor pops and compares whenever any pulse is seen.
module tb_baud_gen_param;
  localparam int unsigned DIV_W = 16;
  localparam int OS = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic             resync = 1'b0;
  logic [2:0]       baud_select = 3'd0;
  logic             use_custom = 1'b0;
  logic [DIV_W-1:0] div_custom = '0;
  logic             sample_ENABLE;
  logic             mid_ENABLE;
  logic             bit_ENABLE;
  logic [DIV_W-1:0] div_active;

  typedef struct {
    int   cyc;
    logic m;
    logic b;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  compared = 0;
  int  mismatched = 0;
  int  n0;

  baud_gen_param dut (
    .clk(clk), .reset(reset), .enable(enable), .resync(resync),
    .baud_select(baud_select), .use_custom(use_custom), .div_custom(div_custom),
    .sample_ENABLE(sample_ENABLE), .mid_ENABLE(mid_ENABLE), .bit_ENABLE(bit_ENABLE),
    .div_active(div_active)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every observed pulse must match the head of the expectation queue.
  always @(negedge clk) begin : monitor
    ev_t e;
    if (reset && (sample_ENABLE || mid_ENABLE || bit_ENABLE)) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_pulse: cyc=%0d s/m/b=%b%b%b, required no pulse",
                 cyc, sample_ENABLE, mid_ENABLE, bit_ENABLE);
      end else begin
        e = exp_q.pop_front();
        if (cyc != e.cyc || sample_ENABLE !== 1'b1 || mid_ENABLE !== e.m || bit_ENABLE !== e.b) begin
          mismatched++;
          $display("FAIL pulse: got cyc=%0d s/m/b=%b%b%b, required cyc=%0d s/m/b=1%b%b",
                   cyc, sample_ENABLE, mid_ENABLE, bit_ENABLE, e.cyc, e.m, e.b);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic push_run(input int first, input int d, input int n, input int idx0);
    for (int k = 0; k < n; k++) begin
      int ix;
      ix = (idx0 + k) % OS;
      exp_q.push_back('{first + k * d, (ix == OS / 2 - 1), (ix == OS - 1)});
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the resync edge with its number.
  task automatic start_run(output int n);
    enable = 1'b1;
    resync = 1'b1;
    @(negedge clk);
    resync = 1'b0;
    n = cyc;
  endtask

  task automatic stop_run();
    enable = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int l;
    #12;
    chk("reset_sample", 32'(sample_ENABLE), 0);
    chk("reset_mid", 32'(mid_ENABLE), 0);
    chk("reset_bit", 32'(bit_ENABLE), 0);
    chk("reset_div", 32'(div_active), 10417);
    @(negedge clk);
    reset = 1'b1;
    baud_select = 3'd7;
    repeat (2) @(negedge clk);
    chk("idle_div_115200", 32'(div_active), 27);

    // 115200 baud from resync: samples every 27, mid at 216, bit at 432/864
    start_run(n0);
    push_run(n0 + 27, 27, 32, 0);
    wait_cyc(n0 + 864);
    chk("run_div_27", 32'(div_active), 27);
    stop_run();

    // Rate change mid-period completes the current period first
    start_run(n0);
    push_run(n0 + 27, 27, 1, 0);
    push_run(n0 + 81, 54, 2, 1);
    wait_cyc(n0 + 10);
    baud_select = 3'd6;
    wait_cyc(n0 + 26);
    chk("div_before_wrap", 32'(div_active), 27);
    wait_cyc(n0 + 27);
    chk("div_after_wrap", 32'(div_active), 54);
    wait_cyc(n0 + 135);
    stop_run();

    // Custom divisors 0 and 1 clamp to 2, then 5
    use_custom = 1'b1;
    div_custom = '0;
    baud_select = 3'd7;
    repeat (2) @(negedge clk);
    start_run(n0);
    div_custom = 16'd1;
    push_run(n0 + 2, 2, 2, 0);
    push_run(n0 + 9, 5, 2, 2);
    chk("custom_div0", 32'(div_active), 2);
    wait_cyc(n0 + 3);
    div_custom = 16'd5;
    chk("custom_div1", 32'(div_active), 2);
    wait_cyc(n0 + 5);
    chk("custom_div5", 32'(div_active), 5);
    wait_cyc(n0 + 14);
    stop_run();
    use_custom = 1'b0;
    repeat (2) @(negedge clk);

    // Resync coincident with a wrap, then enable=0 with resync on a wrap edge
    start_run(n0);
    push_run(n0 + 27, 27, 1, 0);
    push_run(n0 + 81, 27, 1, 0);
    wait_cyc(n0 + 53);
    resync = 1'b1;
    wait_cyc(n0 + 54);
    resync = 1'b0;
    wait_cyc(n0 + 107);
    enable = 1'b0;
    resync = 1'b1;
    wait_cyc(n0 + 108);
    baud_select = 3'd6;
    wait_cyc(n0 + 110);
    resync = 1'b0;
    wait_cyc(n0 + 111);
    chk("idle_div_reload", 32'(div_active), 54);
    wait_cyc(n0 + 140);
    enable = 1'b1;
    l = cyc;
    push_run(l + 54, 54, 2, 0);
    wait_cyc(l + 108);
    stop_run();

    // 300 baud: three full periods
    baud_select = 3'd0;
    repeat (2) @(negedge clk);
    start_run(n0);
    push_run(n0 + 10417, 10417, 3, 0);
    chk("div_300", 32'(div_active), 10417);
    wait_cyc(n0 + 3 * 10417);
    stop_run();

    // Async reset while the index-9 sample pulse is high
    baud_select = 3'd7;
    repeat (2) @(negedge clk);
    start_run(n0);
    push_run(n0 + 27, 27, 10, 0);
    wait_cyc(n0 + 270);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_sample", 32'(sample_ENABLE), 0);
    chk("async_rst_div", 32'(div_active), 10417);
    repeat (3) @(negedge clk);
    chk("rst_hold_pulses", 32'({mid_ENABLE, bit_ENABLE, sample_ENABLE}), 0);
    reset = 1'b1;
    resync = 1'b1;
    @(negedge clk);
    resync = 1'b0;
    n0 = cyc;
    chk("post_rst_div", 32'(div_active), 27);
    push_run(n0 + 27, 27, 8, 0);
    wait_cyc(n0 + 216);
    stop_run();

    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
